// File: rtl/debounce_pkg.sv
// Shared types and default timing constants for the push-button debouncers.
// Used by button_debouncer, main and the benches.
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW     = 2'd0,
        S_RISING  = 2'd1,
        S_HIGH    = 2'd2,
        S_FALLING = 2'd3
    } debounce_state_t;

    // 10 ms stability window and 1 s long-press threshold at 12 MHz
    localparam int DEFAULT_BOUNCE_CYCLES     = 120_000;
    localparam int DEFAULT_LONG_PRESS_CYCLES = 12_000_000;

    // Debounced level implied by an FSM state
    function automatic logic level_of(input debounce_state_t st);
        logic lvl;
        case (st)
            S_HIGH:    lvl = 1'b1;
            S_FALLING: lvl = 1'b1;
            S_LOW:     lvl = 1'b0;
            S_RISING:  lvl = 1'b0;
            default:   lvl = 1'b0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchronizer bringing an asynchronous single-bit input into the clk domain.
// Both stages clear to 0 on reset.
module synchronizer (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Metastability filter: first stage may go metastable, second stage resolves it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/button_debouncer.sv
// Debounces one raw push-button pin and emits a clean level plus one-cycle
// pressed / released / long_press pulses, all registered.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int BOUNCE_CYCLES     = DEFAULT_BOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic level,
    output logic pressed,
    output logic released,
    output logic long_press
);

    localparam int CNT_W  = $clog2(BOUNCE_CYCLES);
    localparam int LCNT_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BOUNCE_CYCLES - 1);
    localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [LCNT_W-1:0] LCNT_MAX  = LCNT_W'(LONG_PRESS_CYCLES);

    logic            s_s;
    debounce_state_t state_r;
    debounce_state_t state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [LCNT_W-1:0] lcnt_r;
    logic [LCNT_W-1:0] lcnt_nxt_s;
    logic level_r;
    logic pressed_r;
    logic released_r;
    logic long_press_r;
    logic pressed_nxt_s;
    logic released_nxt_s;
    logic long_press_nxt_s;

    synchronizer u_sync (
        .clk (clk),
        .rst (rst),
        .d   (button),
        .q   (s_s)
    );

    // Next-state, counter and pulse decode; every decision looks only at the synchronized pin
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        lcnt_nxt_s       = lcnt_r;
        pressed_nxt_s    = 1'b0;
        released_nxt_s   = 1'b0;
        long_press_nxt_s = 1'b0;

        case (state_r)
            S_LOW: begin
                if (s_s) begin
                    state_nxt_s = S_RISING;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = S_LOW;
                end
            end

            S_RISING: begin
                if (!s_s) begin
                    state_nxt_s = S_LOW;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s   = S_HIGH;
                    pressed_nxt_s = 1'b1;
                    lcnt_nxt_s    = {LCNT_W{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end

            S_HIGH: begin
                if (!s_s) begin
                    state_nxt_s = S_FALLING;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else if (lcnt_r == LCNT_LAST) begin
                    // Only this step fires; saturation below keeps it to once per press
                    lcnt_nxt_s       = LCNT_MAX;
                    long_press_nxt_s = 1'b1;
                end else if (lcnt_r < LCNT_MAX) begin
                    lcnt_nxt_s = lcnt_r + LCNT_W'(1);
                end else begin
                    lcnt_nxt_s = lcnt_r;
                end
            end

            S_FALLING: begin
                // A bounce back to high resumes the long-press count where it was
                if (s_s) begin
                    state_nxt_s = S_HIGH;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s    = S_LOW;
                    released_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end

            default: begin
                state_nxt_s = S_LOW;
                cnt_nxt_s   = {CNT_W{1'b0}};
                lcnt_nxt_s  = {LCNT_W{1'b0}};
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_LOW;
            cnt_r        <= {CNT_W{1'b0}};
            lcnt_r       <= {LCNT_W{1'b0}};
            level_r      <= 1'b0;
            pressed_r    <= 1'b0;
            released_r   <= 1'b0;
            long_press_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            lcnt_r       <= lcnt_nxt_s;
            level_r      <= level_of(state_nxt_s);
            pressed_r    <= pressed_nxt_s;
            released_r   <= released_nxt_s;
            long_press_r <= long_press_nxt_s;
        end
    end

    assign level      = level_r;
    assign pressed    = pressed_r;
    assign released   = released_r;
    assign long_press = long_press_r;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with BOUNCE_CYCLES=20, LONG_PRESS_CYCLES=100.
// Pulses are counted at the falling edge; expected latencies are hand-derived (20+3, 100).
module tb_button_debouncer;

    localparam int BC  = 20;
    localparam int LPC = 100;
    localparam int LAT = BC + 3;

    logic clk = 1'b0;
    logic rst;
    logic button;
    logic level;
    logic pressed;
    logic released;
    logic long_press;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    int n_pr = 0;
    int n_rel = 0;
    int n_long = 0;
    int last_pr = 0;
    int last_rel = 0;
    int last_long = 0;
    int mutex_err = 0;
    bit loop_on = 1'b0;
    byte seq[$];

    button_debouncer #(
        .BOUNCE_CYCLES     (BC),
        .LONG_PRESS_CYCLES (LPC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .button     (button),
        .level      (level),
        .pressed    (pressed),
        .released   (released),
        .long_press (long_press)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse bookkeeping, sampled away from the active edge
    always @(negedge clk) begin
        if (pressed === 1'b1) begin
            n_pr++;
            last_pr = cyc;
            if (loop_on) seq.push_back(8'h50);
        end
        if (released === 1'b1) begin
            n_rel++;
            last_rel = cyc;
            if (loop_on) seq.push_back(8'h52);
        end
        if (long_press === 1'b1) begin
            n_long++;
            last_long = cyc;
        end
        if (pressed === 1'b1 && (released === 1'b1 || long_press === 1'b1)) mutex_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Random sub-period toggling, then a clean opposite level, then the final level at a falling edge
    task automatic bounce(input logic fin, output int t_set);
        int n;
        n = $urandom_range(30, 10);
        for (int i = 0; i < n; i++) begin
            #($urandom_range(15, 1));
            button = ~button;
        end
        @(negedge clk);
        button = ~fin;
        cycles(3);
        button = fin;
        t_set = cyc;
    endtask

    initial begin
        int t0;
        int p0;
        int r0;
        int l0;
        int pr_cyc;
        logic [31:0] exp_c;

        // Reset held with the pin pressed
        rst = 1'b1;
        button = 1'b1;
        cycles(5);
        check("rst_level", level, 0);
        check("rst_pressed", pressed, 0);
        check("rst_released", released, 0);
        check("rst_long", long_press, 0);
        p0 = n_pr; r0 = n_rel;
        rst = 1'b0;
        t0 = cyc;
        cycles(30);
        check("rst_rel_press_cnt", n_pr - p0, 1);
        check("rst_rel_press_lat", last_pr - t0, LAT);
        check("rst_rel_level", level, 1);
        check("rst_rel_no_release", n_rel - r0, 0);

        // Clean release
        r0 = n_rel;
        button = 1'b0;
        t0 = cyc;
        cycles(30);
        check("release_cnt", n_rel - r0, 1);
        check("release_lat", last_rel - t0, LAT);
        check("release_level", level, 0);

        // Bouncy press
        p0 = n_pr; r0 = n_rel;
        bounce(1'b1, t0);
        cycles(30);
        check("bouncy_press_cnt", n_pr - p0, 1);
        check("bouncy_press_lat", last_pr - t0, LAT);
        check("bouncy_level", level, 1);
        check("bouncy_no_release", n_rel - r0, 0);

        // Short high glitch inside steady low
        button = 1'b0;
        cycles(30);
        p0 = n_pr; r0 = n_rel; l0 = n_long;
        button = 1'b1;
        cycles(10);
        button = 1'b0;
        cycles(40);
        check("hi_glitch_no_press", n_pr - p0, 0);
        check("hi_glitch_no_release", n_rel - r0, 0);
        check("hi_glitch_level", level, 0);

        // Short low glitch inside steady high
        button = 1'b1;
        cycles(30);
        r0 = n_rel;
        button = 1'b0;
        cycles(10);
        button = 1'b1;
        cycles(40);
        check("lo_glitch_no_release", n_rel - r0, 0);
        check("lo_glitch_level", level, 1);
        button = 1'b0;
        cycles(30);
        check("glitch_no_long", n_long - l0, 0);

        // Long press held 150 cycles past pressed
        p0 = n_pr; l0 = n_long;
        button = 1'b1;
        t0 = cyc;
        cycles(30);
        check("long_press_cnt", n_pr - p0, 1);
        check("long_press_lat", last_pr - t0, LAT);
        pr_cyc = last_pr;
        cycles(pr_cyc + 150 - cyc);
        check("long_cnt", n_long - l0, 1);
        check("long_lat", last_long - pr_cyc, LPC);
        r0 = n_rel;
        button = 1'b0;
        t0 = cyc;
        cycles(30);
        check("long_release_cnt", n_rel - r0, 1);
        check("long_release_lat", last_rel - t0, LAT);
        check("long_single", n_long - l0, 1);

        // Reset 10 cycles into qualification
        p0 = n_pr;
        button = 1'b1;
        cycles(13);
        rst = 1'b1;
        #1;
        check("midrst_level", level, 0);
        check("midrst_pressed", pressed, 0);
        cycles(3);
        check("midrst_no_press", n_pr - p0, 0);
        rst = 1'b0;
        t0 = cyc;
        cycles(30);
        check("midrst_press_cnt", n_pr - p0, 1);
        check("midrst_press_lat", last_pr - t0, LAT);

        // Reset while high clears the level without waiting for an edge
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_level", level, 0);
        button = 1'b0;
        cycles(3);
        rst = 1'b0;
        cycles(5);

        // Sequencer loop with bounces on both edges
        p0 = n_pr; r0 = n_rel;
        loop_on = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bounce(1'b1, t0);
            cycles(125);
            bounce(1'b0, t0);
            cycles(125);
        end
        loop_on = 1'b0;
        check("loop_press_cnt", n_pr - p0, 5);
        check("loop_release_cnt", n_rel - r0, 5);
        check("loop_seq_len", seq.size(), 10);
        for (int i = 0; i < 10; i++) begin
            exp_c = (i % 2 == 0) ? 32'h50 : 32'h52;
            check("loop_seq", (i < seq.size()) ? {24'h0, seq[i]} : 32'h0, exp_c);
        end
        check("mutex", mutex_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
